// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding, baud codes and
// the round-robin pointer helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StGrant,
      StWrite,
      StWaitHi,
      StWaitLo
   } sched_state_e;

   localparam logic [2:0] BaudSel0 = 3'b000;
   localparam logic [2:0] BaudSel1 = 3'b001;
   localparam logic [2:0] BaudSel2 = 3'b010;
   localparam logic [2:0] BaudSel3 = 3'b011;
   localparam logic [2:0] BaudSel4 = 3'b100;
   localparam logic [2:0] BaudSel5 = 3'b101;
   localparam logic [2:0] BaudSel6 = 3'b110;
   localparam logic [2:0] BaudSel7 = 3'b111;

   // Advance a source index by one, wrapping at n.
   function automatic logic [2:0] rr_wrap_inc(input logic [2:0] idx, input int unsigned n);
      if (32'(idx) + 32'd1 >= n) begin
         return 3'd0;
      end
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: searches from the source after i_last and returns the
// first requesting source as both a one-hot vector and an index.
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [2:0]         i_last,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [2:0]         o_idx,
   output logic               o_any
);

   logic [7:0] w_valid8;
   logic [2:0] w_cand;
   logic       w_found;

   assign w_valid8 = 8'(i_valid);

   always_comb begin
      w_cand   = i_last;
      w_found  = 1'b0;
      o_idx    = i_last;
      o_onehot = '0;
      for (int unsigned n = 0; n < NUM_REQ; n++) begin
         w_cand = rr_wrap_inc(w_cand, NUM_REQ);
         if (!w_found && w_valid8[w_cand]) begin
            w_found = 1'b1;
            o_idx   = w_cand;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         o_onehot[i] = w_found && (o_idx == 3'(i));
      end
      o_any = w_found;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_TX_SCHED_STATS_EN to add the byte_count completed-byte counter output.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned BUSY_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 cfg_enable,
   input  logic [2:0]           cfg_baud_select,
   output logic [7:0]           Tx_DATA,
   output logic                 Tx_WR,
   output logic                 Tx_EN,
   output logic [2:0]           baud_select,
   input  logic                 Tx_BUSY,
   output logic [2:0]           grant_id,
`ifdef UART_TX_SCHED_STATS_EN
   output logic [15:0]          byte_count,
`endif
   output logic                 err_timeout
);

   localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

   sched_state_e        r_state;
   logic [NUM_REQ-1:0]  r_req_ready;
   logic [7:0]          r_tx_data;
   logic                r_tx_wr;
   logic                r_tx_en;
   logic [2:0]          r_baud;
   logic [2:0]          r_grant_id;
   logic [2:0]          r_win_idx;
   logic                r_err;
   logic [CntW-1:0]     r_cnt;
`ifdef UART_TX_SCHED_STATS_EN
   logic [15:0]         r_byte_count;
`endif

   logic [NUM_REQ-1:0]  w_onehot;
   logic [2:0]          w_idx;
   logic                w_any;
   logic [7:0]          w_win_data;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_valid  (req_valid),
      .i_last   (r_grant_id),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

   always_comb begin
      w_win_data = 8'h00;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_win_idx == 3'(i)) begin
            w_win_data = req_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_req_ready  <= '0;
         r_tx_data    <= 8'h00;
         r_tx_wr      <= 1'b0;
         r_tx_en      <= 1'b0;
         r_baud       <= BaudSel0;
         r_grant_id   <= 3'(NUM_REQ - 1);
         r_win_idx    <= 3'd0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
`ifdef UART_TX_SCHED_STATS_EN
         r_byte_count <= 16'h0000;
`endif
      end else begin
         r_tx_en     <= cfg_enable;
         r_tx_wr     <= 1'b0;
         r_req_ready <= '0;
         unique case (r_state)
            StIdle: begin
               r_baud <= cfg_baud_select;
               // The pick is made here so req_ready is already up during GRANT.
               if (cfg_enable && !Tx_BUSY && w_any) begin
                  r_req_ready <= w_onehot;
                  r_win_idx   <= w_idx;
                  r_state     <= StGrant;
               end
            end
            StGrant: begin
               if (|(req_valid & r_req_ready)) begin
                  r_tx_data  <= w_win_data;
                  r_grant_id <= r_win_idx;
                  r_tx_wr    <= 1'b1;
                  r_state    <= StWrite;
               end else begin
                  r_state <= StIdle;
               end
            end
            StWrite: begin
               r_cnt   <= CntW'(1);
               r_state <= StWaitHi;
            end
            StWaitHi: begin
               if (Tx_BUSY) begin
                  r_state <= StWaitLo;
               end else if (r_cnt >= CntW'(BUSY_TIMEOUT - 1)) begin
                  // Flag lands on cycle BUSY_TIMEOUT after the write strobe.
                  r_err   <= 1'b1;
                  r_state <= StIdle;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StWaitLo: begin
               if (!Tx_BUSY) begin
                  r_state <= StIdle;
`ifdef UART_TX_SCHED_STATS_EN
                  r_byte_count <= r_byte_count + 16'd1;
`endif
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign Tx_DATA     = r_tx_data;
   assign Tx_WR       = r_tx_wr;
   assign Tx_EN       = r_tx_en;
   assign baud_select = r_baud;
   assign grant_id    = r_grant_id;
   assign err_timeout = r_err;
`ifdef UART_TX_SCHED_STATS_EN
   assign byte_count  = r_byte_count;
`endif

endmodule
